// File: rtl/sipo_word_serializer_pkg.sv
// rtl/sipo_word_serializer_pkg.sv - shared types and width helpers for the serializer
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_GAP_CYCLES  = 1;
    localparam int DEFAULT_BIT_CNT_W   = $clog2(DEFAULT_DATA_WIDTH);
    localparam int DEFAULT_GAP_CNT_W   = $clog2(DEFAULT_GAP_CYCLES + 1);

    function automatic int bit_cnt_w(input int data_width);
        return $clog2(data_width);
    endfunction

    function automatic int gap_cnt_w(input int gap_cycles);
        return $clog2(gap_cycles + 1);
    endfunction

    function automatic bit params_ok(input int data_width, input int gap_cycles);
        return (data_width >= 2) && (gap_cycles >= 1);
    endfunction

endpackage

// File: rtl/sipo_word_serializer_if.sv
// rtl/sipo_word_serializer_if.sv - parallel word valid/ready handshake into the serializer
interface sipo_word_serializer_if
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sipo_word_serializer_hold_buf.sv
// rtl/sipo_word_serializer_hold_buf.sv - one-entry holding register for the next word
module word_hold_buf
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);
    logic                  full_q;
    logic [DATA_WIDTH-1:0] data_q;

    // A write wins over a read; the serializer never issues both together.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr) begin
            full_q <= 1'b1;
            data_q <= wdata;
        end else if (rd) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign data = data_q;
endmodule

// File: rtl/sipo_word_serializer.sv
// rtl/sipo_word_serializer.sv - serializes parallel words onto serial_out framed by shift_en
module sipo_word_serializer
    import sipo_pkg::*;
#(
    parameter bit SHIFT_LEFT = 1'b1,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    arst_n,
    sipo_word_serializer_if.slave   in_if,
    output logic                    serial_out,
    output logic                    shift_en,
    output logic                    word_done,
    output logic                    busy
);
    localparam int BW = bit_cnt_w(DATA_WIDTH);
    localparam int GW = gap_cnt_w(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    generate
        if (!params_ok(DATA_WIDTH, GAP_CYCLES)) begin : g_bad_params
            $error("sipo_word_serializer: DATA_WIDTH must be >= 2 and GAP_CYCLES >= 1");
        end
    endgenerate

    ser_state_e            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic                  serial_q, serial_d;

    logic                  buf_wr, buf_rd, buf_full;
    logic [DATA_WIDTH-1:0] buf_data, load_word;
    logic                  accept, load, last_bit, last_gap;

    function automatic logic edge_bit(input logic [DATA_WIDTH-1:0] w);
        return SHIFT_LEFT ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_once(input logic [DATA_WIDTH-1:0] w);
        return SHIFT_LEFT ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    word_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold_buf (
        .clk   (clk),
        .arst_n(arst_n),
        .wr    (buf_wr),
        .rd    (buf_rd),
        .wdata (in_if.in_data),
        .full  (buf_full),
        .data  (buf_data)
    );

    assign in_if.in_ready = (state_q == IDLE) | ~buf_full;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign last_bit       = (bit_cnt_q == BIT_LAST);
    assign last_gap       = (gap_cnt_q == GAP_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sreg_d    = sreg_q;
        serial_d  = 1'b0;
        buf_wr    = 1'b0;
        buf_rd    = 1'b0;
        load      = 1'b0;
        load_word = in_if.in_data;
        unique case (state_q)
            IDLE: begin
                if (accept) load = 1'b1;
            end
            SHIFT: begin
                if (accept) buf_wr = 1'b1;
                if (last_bit) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    serial_d  = edge_bit(sreg_q);
                    sreg_d    = shift_once(sreg_q);
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            GAP: begin
                if (last_gap) begin
                    // The buffered word has priority; in_ready is low then, so no collision.
                    if (buf_full) begin
                        buf_rd    = 1'b1;
                        load      = 1'b1;
                        load_word = buf_data;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        gap_cnt_d = '0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                    if (accept) buf_wr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The first bit is presented straight from the loaded word, the rest from sreg.
        if (load) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            serial_d  = edge_bit(load_word);
            sreg_d    = shift_once(load_word);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sreg_q    <= '0;
            serial_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sreg_q    <= sreg_d;
            serial_q  <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign shift_en   = (state_q == SHIFT);
    assign word_done  = (state_q == GAP) && (gap_cnt_q == '0);
    assign busy       = (state_q != IDLE) | buf_full;
endmodule

// File: tb/tb_sipo_word_serializer.sv
// tb/tb_sipo_word_serializer.sv - directed bench for the word serializer
module tb_sipo_word_serializer;
    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    sipo_word_serializer_if #(.DATA_WIDTH(32)) if_a ();
    sipo_word_serializer_if #(.DATA_WIDTH(32)) if_b ();

    logic so_a, se_a, wd_a, busy_a;
    logic so_b, se_b, wd_b, busy_b;

    sipo_word_serializer #(.SHIFT_LEFT(1'b1), .DATA_WIDTH(32), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .arst_n(arst_n), .in_if(if_a.slave),
        .serial_out(so_a), .shift_en(se_a), .word_done(wd_a), .busy(busy_a)
    );

    sipo_word_serializer #(.SHIFT_LEFT(1'b0), .DATA_WIDTH(32), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .arst_n(arst_n), .in_if(if_b.slave),
        .serial_out(so_b), .shift_en(se_b), .word_done(wd_b), .busy(busy_b)
    );

    // Downstream SIPO registers: MSB-first shifts left, LSB-first shifts right.
    logic [31:0] par_a = '0, par_b = '0;
    always @(posedge clk) begin
        if (se_a) par_a <= {par_a[30:0], so_a};
        if (se_b) par_b <= {so_b, par_b[31:1]};
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        sel;
        logic [31:0] data;
        logic        first_bit;
        logic        last_bit;
        logic [31:0] exp_par;
    } vec_t;
    vec_t vecs[6];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic sel, input logic v, input logic [31:0] d);
        if (sel) begin
            if_b.in_valid = v;
            if_b.in_data  = d;
        end else begin
            if_a.in_valid = v;
            if_a.in_data  = d;
        end
    endtask

    function automatic logic g_se(input logic sel);   return sel ? se_b : se_a;                 endfunction
    function automatic logic g_so(input logic sel);   return sel ? so_b : so_a;                 endfunction
    function automatic logic g_wd(input logic sel);   return sel ? wd_b : wd_a;                 endfunction
    function automatic logic g_busy(input logic sel); return sel ? busy_b : busy_a;             endfunction
    function automatic logic g_rdy(input logic sel);  return sel ? if_b.in_ready : if_a.in_ready; endfunction
    function automatic logic [31:0] g_par(input logic sel); return sel ? par_b : par_a;        endfunction

    task automatic run_single(input vec_t v);
        int          gap = v.sel ? 3 : 1;
        int          nshift = 0;
        int          nwd = 0;
        logic [31:0] col = '0;
        set_in(v.sel, 1'b1, v.data);
        tick();
        set_in(v.sel, 1'b0, '0);
        for (int k = 0; k < 32; k++) begin
            if (g_se(v.sel)) nshift++;
            if (g_wd(v.sel)) nwd++;
            if (v.sel) col[k] = g_so(v.sel);
            else       col[31-k] = g_so(v.sel);
            tick();
        end
        check32("single_shift_cycles", nshift, 32);
        check32("single_early_word_done", nwd, 0);
        check1("single_first_bit", v.sel ? col[0] : col[31], v.first_bit);
        check1("single_last_bit", v.sel ? col[31] : col[0], v.last_bit);
        check32("single_serial_word", col, v.exp_par);
        check1("single_word_done", g_wd(v.sel), 1'b1);
        check1("single_gap_shift_en", g_se(v.sel), 1'b0);
        check1("single_gap_serial_out", g_so(v.sel), 1'b0);
        check32("single_parallel", g_par(v.sel), v.exp_par);
        nwd = 0;
        for (int g = 1; g < gap; g++) begin
            tick();
            if (g_wd(v.sel) || g_se(v.sel)) nwd++;
        end
        check32("single_gap_tail_quiet", nwd, 0);
        tick();
        check1("single_idle_busy", g_busy(v.sel), 1'b0);
        check1("single_idle_ready", g_rdy(v.sel), 1'b1);
    endtask

    initial begin
        int          cnt;
        int          cnt2;
        logic [31:0] col;
        logic [31:0] p68;

        vecs[0] = '{1'b0, 32'hA5A5_0F0F, 1'b1, 1'b1, 32'hA5A5_0F0F};
        vecs[1] = '{1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001};
        vecs[2] = '{1'b0, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000};
        vecs[3] = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000};
        vecs[4] = '{1'b0, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001};
        vecs[5] = '{1'b1, 32'hA5A5_0F0F, 1'b1, 1'b1, 32'hA5A5_0F0F};

        arst_n = 1'b0;
        set_in(1'b0, 1'b0, '0);
        set_in(1'b1, 1'b0, '0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check1("reset_in_ready", g_rdy(s[0]), 1'b1);
            check1("reset_serial_out", g_so(s[0]), 1'b0);
            check1("reset_shift_en", g_se(s[0]), 1'b0);
            check1("reset_word_done", g_wd(s[0]), 1'b0);
            check1("reset_busy", g_busy(s[0]), 1'b0);
        end
        arst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // Back-to-back on A, plus a word offered on the draining GAP cycle.
        set_in(1'b0, 1'b1, 32'h1111_1111);
        tick();
        check1("b2b_ready_cycle1", if_a.in_ready, 1'b1);
        if_a.in_data = 32'h2222_2222;
        tick();
        set_in(1'b0, 1'b0, '0);
        cnt = 0;
        for (int c = 2; c <= 32; c++) begin
            if (!if_a.in_ready) cnt++;
            tick();
        end
        check32("b2b_ready_low_2_32", cnt, 31);
        check1("b2b_ready_low_33", if_a.in_ready, 1'b0);
        check1("b2b_word_done_33", wd_a, 1'b1);
        check32("b2b_parallel_33", par_a, 32'h1111_1111);
        set_in(1'b0, 1'b1, 32'h3333_3333);
        tick();
        set_in(1'b0, 1'b0, '0);
        check1("b2b_ready_after_drain", if_a.in_ready, 1'b1);
        cnt = 0;
        col = '0;
        for (int k = 0; k < 32; k++) begin
            if (se_a) cnt++;
            col[31-k] = so_a;
            tick();
        end
        check32("b2b_second_shift_cycles", cnt, 32);
        check32("b2b_second_serial", col, 32'h2222_2222);
        check1("b2b_word_done_66", wd_a, 1'b1);
        check32("b2b_parallel_66", par_a, 32'h2222_2222);
        tick();
        check1("b2b_no_third_word", busy_a, 1'b0);

        // GAP_CYCLES=3 on B: shift 1-32, gap 33-35, shift 36-67, gap 68-70.
        set_in(1'b1, 1'b1, 32'h1234_5678);
        tick();
        if_b.in_data = 32'h9ABC_DEF0;
        tick();
        set_in(1'b1, 1'b0, '0);
        cnt = 0;
        cnt2 = 0;
        col = '0;
        p68 = '0;
        for (int c = 2; c <= 71; c++) begin
            if (se_b !== ((c <= 32) || (c >= 36 && c <= 67))) cnt++;
            if (wd_b !== ((c == 33) || (c == 68))) cnt2++;
            if (c >= 36 && c <= 67) col[c-36] = so_b;
            if (c == 68) p68 = par_b;
            tick();
        end
        check32("gap3_shift_en_pattern_errs", cnt, 0);
        check32("gap3_word_done_pattern_errs", cnt2, 0);
        check32("gap3_second_serial", col, 32'h9ABC_DEF0);
        check32("gap3_second_parallel", p68, 32'h9ABC_DEF0);
        check1("gap3_idle_busy", busy_b, 1'b0);

        // Reset during cycle 10 of a shift with the buffer full.
        set_in(1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        if_a.in_data = 32'h0BAD_BEEF;
        tick();
        set_in(1'b0, 1'b0, '0);
        repeat (8) tick();
        check1("rst_pre_busy", busy_a, 1'b1);
        check1("rst_pre_ready", if_a.in_ready, 1'b0);
        #2 arst_n = 1'b0;
        #1;
        check1("rst_shift_en", se_a, 1'b0);
        check1("rst_serial_out", so_a, 1'b0);
        check1("rst_word_done", wd_a, 1'b0);
        check1("rst_in_ready", if_a.in_ready, 1'b1);
        check1("rst_busy", busy_a, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (wd_a || se_a || busy_a) cnt++;
            tick();
        end
        check32("rst_no_activity_after", cnt, 0);
        run_single('{1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_word_serializer.md
# sipo_word_serializer

Upstream driver for the serial-in/parallel-out register. Accepts parallel words over a valid/ready handshake and emits each one bit-serially on `serial_out`, with `shift_en` framing the word. It then holds `shift_en` low for a gap so the downstream register presents the assembled word. A one-entry holding buffer allows back-to-back words with no idle cycles beyond the gap.

## Interface
Parameters:
- `SHIFT_LEFT`, 1: must match the downstream register. 1 sends MSB first; 0 sends LSB first.
- `DATA_WIDTH`, 32: word width, ≥ 2.
- `GAP_CYCLES`, 1: cycles with `shift_en` low between words, ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock, all state on rising edge.
- `arst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: `in_data` holds a word.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input DATA_WIDTH: word to serialize.
- `serial_out` output 1: current bit; drives downstream `serial_in`.
- `shift_en` output 1: bit valid and shift this cycle; drives downstream `we`.
- `word_done` output 1: one-cycle pulse; downstream parallel output holds the full word this cycle.
- `busy` output 1: state ≠ IDLE or buffer full.

## Operation
- Handshake: a word transfers at a rising edge where `in_valid & in_ready`. `in_data` is sampled only then.
- FSM states:
  - IDLE → SHIFT on accept; word loads directly into the shift register.
  - SHIFT stays for exactly DATA_WIDTH cycles, then goes to GAP.
  - GAP stays for GAP_CYCLES cycles. On the last GAP cycle:
    - if the buffer is full: load from buffer, clear buffer, go to SHIFT;
    - else if accepting a word this cycle: load it directly, go to SHIFT;
    - else go to IDLE.
- Holding buffer (1 entry): words accepted in SHIFT, or in GAP before its last cycle, go to the buffer.
- `in_ready` = (state == IDLE) | (buffer empty).
- Bit order:
  - SHIFT_LEFT=1: bits DATA_WIDTH-1 … 0 in successive SHIFT cycles.
  - SHIFT_LEFT=0: bits 0 … DATA_WIDTH-1.
  - With either setting, the downstream register ends holding `in_data` unmodified.
- Bit counter: `$clog2(DATA_WIDTH)` bits, counts 0 … DATA_WIDTH-1 in SHIFT, cleared on entry. Gap counter: `$clog2(GAP_CYCLES+1)` bits.
- `shift_en` = (state == SHIFT).
- `serial_out` is registered from the shift-register edge bit. It is 0 outside SHIFT.
- `word_done` is high only in the first GAP cycle.

## Timing
- Reset values: `in_ready`=1, `serial_out`=0, `shift_en`=0, `word_done`=0, `busy`=0. State = IDLE, buffer empty, counters 0.
- Latency: accept at edge N (IDLE) → first bit with `shift_en`=1 in cycle N+1. Last bit in cycle N+DATA_WIDTH. `word_done` in cycle N+DATA_WIDTH+1.
- Throughput: back-to-back words take DATA_WIDTH+GAP_CYCLES cycles each, with no IDLE cycle.
- Buffer full while in SHIFT or GAP: `in_ready`=0 until the buffer drains at the last GAP cycle. The new value of `in_ready` appears the cycle after the drain.
- Simultaneous drain and `in_valid` on the last GAP cycle: `in_ready`=0 in that cycle, so nothing is accepted.
- `in_valid` deasserted without a transfer has no effect; there is no requirement that it stay stable.
- Reset asserted mid-word:
  - outputs go to reset values immediately (asynchronous);
  - the in-flight word and the buffered word are discarded;
  - no `word_done` is produced.
- `word_done` never occurs without a preceding DATA_WIDTH-cycle SHIFT run.

## Structure
- Shared package `sipo_pkg` holds:
  - the state enum `ser_state_e` {IDLE, SHIFT, GAP};
  - localparams for the counter widths;
  - elaboration checks (DATA_WIDTH ≥ 2, GAP_CYCLES ≥ 1).
- One sub-module `word_hold_buf`: 1-entry register with `wr`, `rd`, `full`, `data` ports. Everything else lives in the top module.

## Test plan
- Single word, SHIFT_LEFT=1, DATA_WIDTH=32, `in_data`=0xA5A5_0F0F accepted at edge 0 → `serial_out` bits 1,0,1,0,… MSB first in cycles 1–32. `word_done` in cycle 33. Downstream `parallel_out`=0xA5A5_0F0F in cycle 33.
- SHIFT_LEFT=0, `in_data`=0x0000_0001 → `serial_out`=1 in cycle 1, then 0 for cycles 2–32. Downstream reads 0x0000_0001 at `word_done`.
- Back-to-back: 0x1111_1111 then 0x2222_2222 with `in_valid` held, GAP_CYCLES=1 → second accepted in cycle 1 into the buffer. `in_ready`=0 in cycles 2–33. Second word's SHIFT runs cycles 34–65. `word_done` in cycles 33 and 66.
- GAP_CYCLES=3, two words → exactly 3 cycles with `shift_en`=0 between words. `word_done` only in the first of them.
- `arst_n` low for one cycle during cycle 10 of a shift with the buffer full → all outputs at reset values, `in_ready`=1, `busy`=0. No `word_done` follows. The next word is serialized correctly.
